// File: rtl/ddr3_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_wr_arbiter
// Purpose  : Round-robin arbiter sharing the DDR3 write-request port between
//            NM masters; grant held from address handshake to data LAST.
// Revision : 1.0  initial release
// ============================================================================
module ddr3_wr_arbiter #(
  parameter int NM     = 2,
  parameter int ADDR_W = 28,
  parameter int LEN_W  = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NM*ADDR_W-1:0] M_WR_ADDR,
  input  logic [NM*LEN_W-1:0]  M_WR_LEN,
  input  logic [NM-1:0]        M_WR_ADDR_VALID,
  output logic [NM-1:0]        M_WR_ADDR_READY,
  input  logic [NM*32-1:0]     M_WR_DATA,
  input  logic [NM*4-1:0]      M_WR_STRB,
  input  logic [NM-1:0]        M_WR_DATA_VALID,
  input  logic [NM-1:0]        M_WR_DATA_LAST,
  output logic [NM-1:0]        M_WR_DATA_READY,
  output logic [ADDR_W-1:0]    WR_ADDR,
  output logic [LEN_W-1:0]     WR_LEN,
  output logic                 WR_ADDR_VALID,
  input  logic                 WR_ADDR_READY,
  output logic [31:0]          WR_DATA,
  output logic [3:0]           WR_STRB,
  output logic                 WR_DATA_VALID,
  output logic                 WR_DATA_LAST,
  input  logic                 WR_DATA_READY,
  output logic [NM-1:0]        GRANT,
  output logic                 ERR_LEN,
  output logic [1:0]           ERR_MASTER
);

  localparam int         c_CNT_W    = LEN_W + 1;
  localparam logic [1:0] c_ARB_IDLE = 2'd0;
  localparam logic [1:0] c_ARB_ADDR = 2'd1;
  localparam logic [1:0] c_ARB_DATA = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [NM-1:0]      r_grant;
  logic [1:0]         r_gidx;
  logic [1:0]         r_rr_ptr;
  logic [LEN_W-1:0]   r_len_load;
  logic [c_CNT_W-1:0] r_beat_cnt;
  logic               r_err_len;
  logic [1:0]         r_err_master;

  logic               w_req_any;
  logic [1:0]         w_pick;
  logic [NM-1:0]      w_pick_onehot;
  logic [LEN_W-1:0]   w_pick_len;
  logic [ADDR_W-1:0]  w_g_addr;
  logic [LEN_W-1:0]   w_g_len;
  logic               w_g_avalid;
  logic [31:0]        w_g_data;
  logic [3:0]         w_g_strb;
  logic               w_g_dvalid;
  logic               w_g_dlast;
  logic               w_addr_hs;
  logic               w_data_hs;
  logic               w_len_err;
  logic [c_CNT_W:0]   w_cnt_inc;
  logic [c_CNT_W:0]   w_beats_exp;
  logic [1:0]         w_rr_next;

  // Winner is the requester with the smallest forward distance from r_rr_ptr.
  always_comb begin
    int best_d;
    int d;
    best_d        = NM;
    d             = 0;
    w_req_any     = 1'b0;
    w_pick        = '0;
    w_pick_onehot = '0;
    w_pick_len    = '0;
    for (int i = 0; i < NM; i++) begin
      d = i - int'(r_rr_ptr);
      if (d < 0) d = d + NM;
      if (M_WR_ADDR_VALID[i] && (d < best_d)) begin
        best_d           = d;
        w_req_any        = 1'b1;
        w_pick           = 2'(i);
        w_pick_onehot    = '0;
        w_pick_onehot[i] = 1'b1;
        w_pick_len       = M_WR_LEN[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    w_g_addr   = '0;
    w_g_len    = '0;
    w_g_avalid = 1'b0;
    w_g_data   = '0;
    w_g_strb   = '0;
    w_g_dvalid = 1'b0;
    w_g_dlast  = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (r_grant[i]) begin
        w_g_addr   = M_WR_ADDR[i*ADDR_W +: ADDR_W];
        w_g_len    = M_WR_LEN[i*LEN_W +: LEN_W];
        w_g_avalid = M_WR_ADDR_VALID[i];
        w_g_data   = M_WR_DATA[i*32 +: 32];
        w_g_strb   = M_WR_STRB[i*4 +: 4];
        w_g_dvalid = M_WR_DATA_VALID[i];
        w_g_dlast  = M_WR_DATA_LAST[i];
      end
    end
  end

  assign w_addr_hs   = (r_state == c_ARB_ADDR) && w_g_avalid && WR_ADDR_READY;
  assign w_data_hs   = (r_state == c_ARB_DATA) && w_g_dvalid && WR_DATA_READY;
  assign w_cnt_inc   = {1'b0, r_beat_cnt} + {{c_CNT_W{1'b0}}, 1'b1};
  assign w_beats_exp = {2'b00, r_len_load} + {{c_CNT_W{1'b0}}, 1'b1};
  assign w_rr_next   = (int'(r_gidx) == NM - 1) ? 2'd0 : (r_gidx + 2'd1);

  // A short burst is caught at LAST; an overlong one as soon as it passes len+1.
  assign w_len_err = w_data_hs &&
                     (w_g_dlast ? (w_cnt_inc != w_beats_exp) : (w_cnt_inc >= w_beats_exp));

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= c_ARB_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ARB_IDLE: if (w_req_any) w_next_state = c_ARB_ADDR;
      c_ARB_ADDR: if (w_addr_hs) w_next_state = c_ARB_DATA;
      c_ARB_DATA: if (w_data_hs && w_g_dlast) w_next_state = c_ARB_IDLE;
      default:    w_next_state = c_ARB_IDLE;
    endcase
  end

  always_comb begin
    M_WR_ADDR_READY = '0;
    M_WR_DATA_READY = '0;
    WR_ADDR         = '0;
    WR_LEN          = '0;
    WR_ADDR_VALID   = 1'b0;
    WR_DATA         = '0;
    WR_STRB         = '0;
    WR_DATA_VALID   = 1'b0;
    WR_DATA_LAST    = 1'b0;
    case (r_state)
      c_ARB_ADDR: begin
        WR_ADDR         = w_g_addr;
        WR_LEN          = w_g_len;
        WR_ADDR_VALID   = w_g_avalid;
        M_WR_ADDR_READY = r_grant & {NM{WR_ADDR_READY}};
      end
      c_ARB_DATA: begin
        WR_DATA         = w_g_data;
        WR_STRB         = w_g_strb;
        WR_DATA_VALID   = w_g_dvalid;
        WR_DATA_LAST    = w_g_dlast;
        M_WR_DATA_READY = r_grant & {NM{WR_DATA_READY}};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_grant      <= '0;
      r_gidx       <= '0;
      r_rr_ptr     <= '0;
      r_len_load   <= '0;
      r_beat_cnt   <= '0;
      r_err_len    <= 1'b0;
      r_err_master <= '0;
    end else begin
      case (r_state)
        c_ARB_IDLE: begin
          if (w_req_any) begin
            r_grant    <= w_pick_onehot;
            r_gidx     <= w_pick;
            r_len_load <= w_pick_len;
          end
        end
        c_ARB_ADDR: begin
          if (w_addr_hs) r_beat_cnt <= '0;
        end
        c_ARB_DATA: begin
          if (w_data_hs) begin
            // Saturate so a runaway burst cannot wrap back into a legal count.
            if (!(&r_beat_cnt)) r_beat_cnt <= w_cnt_inc[c_CNT_W-1:0];
            if (w_g_dlast) begin
              r_grant  <= '0;
              r_rr_ptr <= w_rr_next;
            end
          end
          if (w_len_err) begin
            if (!r_err_len) r_err_master <= r_gidx;
            r_err_len <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign GRANT      = r_grant;
  assign ERR_LEN    = r_err_len;
  assign ERR_MASTER = r_err_master;

endmodule
`default_nettype wire
